// File: rtl/timer0_engine.sv
// 8051 Timer/Counter 0 count engine: computes next TL0/TH0 per TMOD mode once per machine cycle.
// Optional debug freeze: define TIMER0_DBG_FREEZE_EN to let i_dbg_halt stall the engine.
module timer0_engine #(
  parameter int unsigned PRESCALE = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tl0,
  input  logic [7:0] i_th0,
  input  logic [3:0] i_tmod,
  input  logic       i_tr0,
  input  logic       i_tr1,
  input  logic       i_int0_n,
  input  logic       i_t0,
  input  logic       i_cpu_wr_tl0,
  input  logic       i_cpu_wr_th0,
  input  logic       i_dbg_halt,
  output logic       o_tl0_wr,
  output logic [7:0] o_tl0_byte,
  output logic       o_th0_wr,
  output logic [7:0] o_th0_byte,
  output logic       o_tf0_set,
  output logic       o_tf1_set,
  output logic       o_mc_tick
);

  typedef enum logic [1:0] {
    MODE_13BIT  = 2'd0,
    MODE_16BIT  = 2'd1,
    MODE_RELOAD = 2'd2,
    MODE_SPLIT  = 2'd3
  } mode_e;

  logic [7:0] r_presc;
  logic       r_t0_prev;
  logic       r_tl0_wr;
  logic [7:0] r_tl0_byte;
  logic       r_th0_wr;
  logic [7:0] r_th0_byte;
  logic       r_tf0;
  logic       r_tf0_src_th;
  logic       r_tf1;

  logic       w_halt;
  logic       w_tick_raw;
  logic       w_tick;
  logic       w_run0;
  logic       w_inc0;
  logic       w_inc1;
  mode_e      w_mode;
  logic [5:0] w_lo5_sum;
  logic [8:0] w_tl0_sum;
  logic [8:0] w_th0_sum;

  logic       w_tl0_wr;
  logic [7:0] w_tl0_nxt;
  logic       w_th0_wr;
  logic [7:0] w_th0_nxt;
  logic       w_tf0;
  logic       w_tf0_src_th;
  logic       w_tf1;

`ifdef TIMER0_DBG_FREEZE_EN
  assign w_halt = i_dbg_halt;
`else
  logic w_unused_dbg_halt;
  assign w_unused_dbg_halt = i_dbg_halt;
  assign w_halt = 1'b0;
`endif

  assign w_tick_raw = (r_presc == 8'(PRESCALE - 1));
  assign w_tick     = w_tick_raw & ~w_halt;

  assign w_run0 = i_tr0 & (~i_tmod[3] | i_int0_n);
  assign w_inc0 = i_tmod[2] ? (w_run0 & r_t0_prev & ~i_t0) : w_run0;
  assign w_inc1 = i_tr1;
  assign w_mode = mode_e'(i_tmod[1:0]);

  assign w_lo5_sum = {1'b0, i_tl0[4:0]} + 6'd1;
  assign w_tl0_sum = {1'b0, i_tl0} + 9'd1;
  assign w_th0_sum = {1'b0, i_th0} + 9'd1;

  always_comb begin
    w_tl0_wr     = 1'b0;
    w_tl0_nxt    = i_tl0;
    w_th0_wr     = 1'b0;
    w_th0_nxt    = i_th0;
    w_tf0        = 1'b0;
    w_tf0_src_th = 1'b0;
    w_tf1        = 1'b0;
    unique case (w_mode)
      MODE_13BIT: begin
        if (w_inc0) begin
          w_tl0_wr  = 1'b1;
          w_tl0_nxt = {i_tl0[7:5], w_lo5_sum[4:0]};
          if (w_lo5_sum[5]) begin
            w_th0_wr     = 1'b1;
            w_th0_nxt    = w_th0_sum[7:0];
            w_tf0        = w_th0_sum[8];
            w_tf0_src_th = 1'b1;
          end
        end
      end
      MODE_16BIT: begin
        if (w_inc0) begin
          w_tl0_wr  = 1'b1;
          w_tl0_nxt = w_tl0_sum[7:0];
          if (w_tl0_sum[8]) begin
            w_th0_wr     = 1'b1;
            w_th0_nxt    = w_th0_sum[7:0];
            w_tf0        = w_th0_sum[8];
            w_tf0_src_th = 1'b1;
          end
        end
      end
      MODE_RELOAD: begin
        if (w_inc0) begin
          if (w_tl0_sum[8]) begin
            w_tl0_nxt = i_th0;
            w_tf0     = 1'b1;
          end else begin
            w_tl0_nxt = w_tl0_sum[7:0];
          end
          // a reload of FF onto FF leaves TL0 unchanged, so no write strobe
          w_tl0_wr = (w_tl0_nxt != i_tl0);
        end
      end
      MODE_SPLIT: begin
        if (w_inc0) begin
          w_tl0_wr  = 1'b1;
          w_tl0_nxt = w_tl0_sum[7:0];
          w_tf0     = w_tl0_sum[8];
        end
        if (w_inc1) begin
          w_th0_wr  = 1'b1;
          w_th0_nxt = w_th0_sum[7:0];
          w_tf1     = w_th0_sum[8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc      <= '0;
      r_t0_prev    <= 1'b1;
      r_tl0_wr     <= 1'b0;
      r_tl0_byte   <= '0;
      r_th0_wr     <= 1'b0;
      r_th0_byte   <= '0;
      r_tf0        <= 1'b0;
      r_tf0_src_th <= 1'b0;
      r_tf1        <= 1'b0;
    end else begin
      if (!w_halt) begin
        r_presc <= w_tick_raw ? '0 : r_presc + 8'd1;
      end
      if (w_tick) begin
        r_t0_prev  <= i_t0;
        r_tl0_byte <= w_tl0_nxt;
        r_th0_byte <= w_th0_nxt;
      end
      // strobes live for exactly the cycle after a tick; PRESCALE >= 2 keeps ticks apart
      r_tl0_wr     <= w_tick & w_tl0_wr;
      r_th0_wr     <= w_tick & w_th0_wr;
      r_tf0        <= w_tick & w_tf0;
      r_tf0_src_th <= w_tick & w_tf0_src_th;
      r_tf1        <= w_tick & w_tf1;
    end
  end

  // CPU writes win; an overflow flag follows the write of the register that overflowed
  assign o_tl0_wr   = r_tl0_wr & ~i_cpu_wr_tl0;
  assign o_th0_wr   = r_th0_wr & ~i_cpu_wr_th0;
  assign o_tl0_byte = r_tl0_byte;
  assign o_th0_byte = r_th0_byte;
  assign o_tf0_set  = r_tf0 & ~(r_tf0_src_th ? i_cpu_wr_th0 : i_cpu_wr_tl0);
  assign o_tf1_set  = r_tf1 & ~i_cpu_wr_th0;
  assign o_mc_tick  = w_tick;

endmodule

// File: tb/tb_timer0_engine.sv
// Bench for timer0_engine: SFR model latches the strobes; a scoreboard predicts each update.
module tb_timer0_engine;
  localparam int unsigned PRESCALE = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tmod = 4'h0;
  logic       tr0 = 1'b0, tr1 = 1'b0, int0_n = 1'b1, t0 = 1'b1;
  logic       cpu_wr_tl0 = 1'b0, cpu_wr_th0 = 1'b0, dbg_halt = 1'b0;
  logic [7:0] cpu_tl0 = 8'h00, cpu_th0 = 8'h00;
  logic [7:0] sfr_tl0 = 8'h00, sfr_th0 = 8'h00;

  logic       o_tl0_wr, o_th0_wr, o_tf0_set, o_tf1_set, o_mc_tick;
  logic [7:0] o_tl0_byte, o_th0_byte;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct packed {
    logic       tl0_wr;
    logic [7:0] tl0;
    logic       th0_wr;
    logic [7:0] th0;
    logic       tf0;
    logic       tf0_th;
    logic       tf1;
  } upd_t;

  upd_t sb_q[$];

  int unsigned m_presc = 0;
  logic        m_t0p = 1'b1;
  logic        m_rst_prev = 1'b0;
  logic        m_armed = 1'b0;

  timer0_engine #(.PRESCALE(PRESCALE)) dut (
    .i_clk(clk), .i_rst(rst), .i_tl0(sfr_tl0), .i_th0(sfr_th0), .i_tmod(tmod),
    .i_tr0(tr0), .i_tr1(tr1), .i_int0_n(int0_n), .i_t0(t0),
    .i_cpu_wr_tl0(cpu_wr_tl0), .i_cpu_wr_th0(cpu_wr_th0), .i_dbg_halt(dbg_halt),
    .o_tl0_wr(o_tl0_wr), .o_tl0_byte(o_tl0_byte), .o_th0_wr(o_th0_wr),
    .o_th0_byte(o_th0_byte), .o_tf0_set(o_tf0_set), .o_tf1_set(o_tf1_set),
    .o_mc_tick(o_mc_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference next-state: straightforward wide arithmetic per mode
  function automatic upd_t predict(input logic [7:0] tl, input logic [7:0] th,
                                   input logic [3:0] tm, input logic inc0, input logic inc1);
    upd_t u;
    logic [12:0] v13;
    logic [15:0] v16;
    u = '0;
    case (tm[1:0])
      2'd0: if (inc0) begin
        v13 = {th, tl[4:0]} + 13'd1;
        u.tl0_wr = 1'b1;
        u.tl0 = {tl[7:5], v13[4:0]};
        if (tl[4:0] == 5'h1f) begin
          u.th0_wr = 1'b1; u.th0 = v13[12:5]; u.tf0 = (v13 == 13'd0); u.tf0_th = 1'b1;
        end
      end
      2'd1: if (inc0) begin
        v16 = {th, tl} + 16'd1;
        u.tl0_wr = 1'b1;
        u.tl0 = v16[7:0];
        if (tl == 8'hff) begin
          u.th0_wr = 1'b1; u.th0 = v16[15:8]; u.tf0 = (v16 == 16'd0); u.tf0_th = 1'b1;
        end
      end
      2'd2: if (inc0) begin
        if (tl == 8'hff) begin
          u.tl0 = th; u.tf0 = 1'b1; u.tl0_wr = (th != tl);
        end else begin
          u.tl0 = tl + 8'd1; u.tl0_wr = 1'b1;
        end
      end
      default: begin
        if (inc0) begin
          u.tl0_wr = 1'b1; u.tl0 = tl + 8'd1; u.tf0 = (tl == 8'hff);
        end
        if (inc1) begin
          u.th0_wr = 1'b1; u.th0 = th + 8'd1; u.tf1 = (th == 8'hff);
        end
      end
    endcase
    return u;
  endfunction

  // SFR registers: CPU write has priority over the engine strobe
  always @(posedge clk) begin
    if (cpu_wr_tl0) sfr_tl0 <= cpu_tl0;
    else if (o_tl0_wr) sfr_tl0 <= o_tl0_byte;
    if (cpu_wr_th0) sfr_th0 <= cpu_th0;
    else if (o_th0_wr) sfr_th0 <= o_th0_byte;
  end

  always @(negedge clk) begin
    upd_t e;
    logic exp_tick, run0, inc0, exp_tl_wr, exp_th_wr;
    exp_tick = 1'b0;
    if (m_armed) begin
      if (m_rst_prev) begin
        sb_q.delete();
        check_eq("rst_tl0_wr", o_tl0_wr, 1'b0);
        check_eq("rst_th0_wr", o_th0_wr, 1'b0);
        check_eq("rst_tl0_byte", o_tl0_byte, 8'h00);
        check_eq("rst_th0_byte", o_th0_byte, 8'h00);
        check_eq("rst_tf0", o_tf0_set, 1'b0);
        check_eq("rst_tf1", o_tf1_set, 1'b0);
        check_eq("rst_tick", o_mc_tick, 1'b0);
      end else begin
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        exp_tl_wr = e.tl0_wr & ~cpu_wr_tl0;
        exp_th_wr = e.th0_wr & ~cpu_wr_th0;
        check_eq("tl0_wr", o_tl0_wr, exp_tl_wr);
        if (exp_tl_wr) check_eq("tl0_byte", o_tl0_byte, e.tl0);
        check_eq("th0_wr", o_th0_wr, exp_th_wr);
        if (exp_th_wr) check_eq("th0_byte", o_th0_byte, e.th0);
        check_eq("tf0_set", o_tf0_set, e.tf0 & ~(e.tf0_th ? cpu_wr_th0 : cpu_wr_tl0));
        check_eq("tf1_set", o_tf1_set, e.tf1 & ~cpu_wr_th0);
        exp_tick = (m_presc == PRESCALE - 1);
        check_eq("mc_tick", o_mc_tick, exp_tick);
        if (exp_tick && !rst) begin
          run0 = tr0 & (~tmod[3] | int0_n);
          inc0 = tmod[2] ? (run0 & m_t0p & ~t0) : run0;
          sb_q.push_back(predict(sfr_tl0, sfr_th0, tmod, inc0, tr1));
        end
      end
    end
    if (rst) begin
      m_presc = 0;
      m_t0p = 1'b1;
      m_armed = 1'b1;
    end else begin
      if (exp_tick) m_t0p = t0;
      m_presc = (m_presc == PRESCALE - 1) ? 0 : m_presc + 1;
    end
    m_rst_prev = rst;
  end

  task automatic wait_ticks(input int n);
    int seen = 0;
    int budget = n * int'(PRESCALE) + 4;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (o_mc_tick) seen++;
    end
    check_eq("ticks_seen", 16'(seen), 16'(n));
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  // returns #1 into the strobe cycle that follows the next tick
  task automatic wait_strobe_cycle();
    int budget = int'(PRESCALE) + 4;
    do begin
      @(negedge clk);
      budget--;
    end while (!o_mc_tick && budget > 0);
    check_eq("tick_found", o_mc_tick, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_load(input logic [7:0] tl, input logic [7:0] th);
    cpu_tl0 = tl; cpu_th0 = th;
    cpu_wr_tl0 = 1'b1; cpu_wr_th0 = 1'b1;
    @(posedge clk); #1;
    cpu_wr_tl0 = 1'b0; cpu_wr_th0 = 1'b0;
  endtask

  task automatic setup(input logic [7:0] tl, input logic [7:0] th, input logic [3:0] tm,
                       input logic r0, input logic r1);
    tr0 = 1'b0; tr1 = 1'b0;
    cpu_load(tl, th);
    tmod = tm; tr0 = r0; tr1 = r1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // mode 1 rollover FFFE -> FFFF -> 0000
    setup(8'hfe, 8'hff, 4'b0001, 1'b1, 1'b0);
    wait_ticks(1);
    check_eq("m1_tl0_t1", sfr_tl0, 8'hff);
    check_eq("m1_th0_t1", sfr_th0, 8'hff);
    wait_ticks(1);
    check_eq("m1_tl0_t2", sfr_tl0, 8'h00);
    check_eq("m1_th0_t2", sfr_th0, 8'h00);

    // mode 2 auto-reload
    setup(8'hff, 8'h9c, 4'b0010, 1'b1, 1'b0);
    wait_ticks(1);
    check_eq("m2_reload", sfr_tl0, 8'h9c);
    wait_ticks(1);
    check_eq("m2_inc", sfr_tl0, 8'h9d);
    check_eq("m2_th0", sfr_th0, 8'h9c);

    // mode 0 counter on T0 falling edge
    t0 = 1'b1;
    setup(8'he3, 8'h12, 4'b0100, 1'b1, 1'b0);
    wait_ticks(1);
    t0 = 1'b0;
    wait_ticks(1);
    check_eq("m0_edge_tl0", sfr_tl0, 8'he4);
    wait_ticks(2);
    check_eq("m0_hold_tl0", sfr_tl0, 8'he4);
    check_eq("m0_th0", sfr_th0, 8'h12);
    t0 = 1'b1;

    // mode 0 carry into TH0 and 13-bit overflow
    setup(8'ha0 | 8'h1f, 8'hff, 4'b0000, 1'b1, 1'b0);
    wait_ticks(1);
    check_eq("m0_ovf_tl0", sfr_tl0, 8'ha0);
    check_eq("m0_ovf_th0", sfr_th0, 8'h00);

    // GATE: count only while INT0 high
    int0_n = 1'b0;
    setup(8'h00, 8'h00, 4'b1001, 1'b1, 1'b0);
    wait_ticks(5);
    int0_n = 1'b1;
    wait_ticks(3);
    tr0 = 1'b0;
    check_eq("gate_cnt", {sfr_th0, sfr_tl0}, 16'h0003);

    // mode 3 TH0 timer under TR1
    setup(8'h40, 8'hff, 4'b0011, 1'b0, 1'b1);
    wait_ticks(1);
    tr1 = 1'b0;
    check_eq("m3_th0", sfr_th0, 8'h00);
    check_eq("m3_tl0", sfr_tl0, 8'h40);

    // CPU write to TH0 in the strobe cycle wins over the carry
    setup(8'hff, 8'hff, 4'b0001, 1'b1, 1'b0);
    wait_strobe_cycle();
    cpu_th0 = 8'h55; cpu_wr_th0 = 1'b1;
    @(posedge clk); #1;
    cpu_wr_th0 = 1'b0;
    check_eq("coll_th0", sfr_th0, 8'h55);
    check_eq("coll_tl0", sfr_tl0, 8'h00);

    // reset in a strobe cycle, then reset in a tick cycle discards the pending update
    wait_strobe_cycle();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    check_eq("rst_strobe_tl0", sfr_tl0, 8'h01);
    repeat (PRESCALE - 1) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    check_eq("rst_discard_tl0", sfr_tl0, 8'h01);
    wait_ticks(1);
    check_eq("post_rst_tl0", sfr_tl0, 8'h02);
    tr0 = 1'b0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer0_engine.md
Name: timer0_engine

Overview:
Count engine for 8051 Timer/Counter 0. It sits directly upstream of the TL0/TH0 SFR registers and the TCON flag logic. Each machine cycle it reads the current TL0/TH0 values and the Timer 0 control bits, computes the next count per the TMOD mode, and emits one-cycle write strobes with new byte values. It also emits TF0/TF1 set pulses on overflow.

Parameters:
PRESCALE, 12, clocks per machine cycle; legal range 2..255.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_tl0  input  8  current TL0 value
i_th0  input  8  current TH0 value
i_tmod  input  4  TMOD[3:0]: [3]=GATE, [2]=C/T, [1:0]=M1:M0
i_tr0  input  1  TCON.TR0
i_tr1  input  1  TCON.TR1; gates TH0 in mode 3 only
i_int0_n  input  1  INT0 pin, already synchronised
i_t0  input  1  T0 pin, already synchronised
i_cpu_wr_tl0  input  1  CPU writes TL0 this cycle
i_cpu_wr_th0  input  1  CPU writes TH0 this cycle
i_dbg_halt  input  1  debug freeze; used only with the optional feature
o_tl0_wr  output  1  TL0 write strobe, one cycle
o_tl0_byte  output  8  TL0 next value
o_th0_wr  output  1  TH0 write strobe, one cycle
o_th0_byte  output  8  TH0 next value
o_tf0_set  output  1  TF0 set pulse
o_tf1_set  output  1  TF1 set pulse; mode 3 only
o_mc_tick  output  1  machine-cycle tick, for observation

Behaviour:
- Reset:
  - prescaler = 0; T0 sample register = 1.
  - All outputs = 0, including bytes; any pending update is discarded.
  - Reset asserted mid-count takes effect at the next edge.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - o_mc_tick = 1 combinationally when count == PRESCALE-1.
- Run condition: run0 = i_tr0 & (~i_tmod[3] | i_int0_n).
- Count enable on a tick:
  - C/T=0: inc0 = run0.
  - C/T=1: inc0 = run0 & (t0_prev == 1) & (i_t0 == 0).
  - t0_prev is updated with i_t0 on every tick, whether or not the timer is running.
- Next value is computed at the tick cycle from i_tl0/i_th0 and registered. Strobes appear in the cycle after the tick; the SFR latches one edge later.
- Mode 0 (13-bit):
  - TL0[4:0] is the low 5 bits; TL0[7:5] pass through unchanged.
  - Carry from TL0[4:0]=1F increments TH0.
  - Overflow at TH0=FF and TL0[4:0]=1F: TH0 -> 00, TL0[4:0] -> 00, TF0 pulse.
- Mode 1 (16-bit): {TH0,TL0} + 1; FFFF -> 0000 and TF0 pulse.
- Mode 2 (8-bit auto-reload):
  - TL0 + 1.
  - On FF: TL0 <- i_th0 sampled at the tick, and TF0 pulse.
  - TH0 is never written.
- Mode 3 (split):
  - TL0 is an 8-bit counter using run0/C/T; FF -> 00 sets TF0.
  - TH0 is an 8-bit timer incremented every tick while i_tr1 = 1, with no GATE and no T0 input; FF -> 00 sets TF1.
- Strobe rules:
  - o_tl0_wr / o_th0_wr assert only for registers whose value changes.
  - In modes 0/1, TH0 is written only on carry.
- CPU collision:
  - If i_cpu_wr_tl0 = 1 in the strobe cycle, suppress o_tl0_wr.
  - If i_cpu_wr_th0 = 1 in the strobe cycle, suppress o_th0_wr. The CPU wins; the increment is lost.
  - An overflow pulse is dropped if the write of the register that overflowed is suppressed (mode 0/1: TH0 write; mode 2/3 TL0: TL0 write; mode 3 TH0: TH0 write).
- i_tmod or i_tr0 changing between a tick and its strobe does not alter the registered pending update.

Optional Feature:
TIMER0_DBG_FREEZE_EN:
- Defined:
  - i_dbg_halt = 1 holds the prescaler and t0_prev.
  - o_mc_tick is forced to 0; no new updates are generated.
  - An update already pending still issues.
- Undefined: i_dbg_halt is ignored.

Test Plan:
- Mode 1, C/T=0, TR0=1, TL0=FE, TH0=FF, PRESCALE=12 -> TL0 write FF after tick 1; after tick 2, TL0=00, TH0=00 written and o_tf0_set = 1 for one cycle.
- Mode 2, TH0=9C, TL0=FF, tick -> o_tl0_byte=9C, no TH0 write, TF0 pulse. Next tick -> TL0=9D.
- Mode 0, TL0=E3 (low5=03), TH0=12, counter mode: T0 held 1 then driven 0 over two ticks -> exactly one increment, TL0=E4, TH0 unchanged. T0 held 0 -> no further increments.
- GATE=1, TR0=1, INT0=0 for 5 ticks then 1 for 3 ticks, mode 1 from 0000 -> count reaches 0003.
- Mode 3, TR0=0, TR1=1, TH0=FF -> TH0 writes 00 with o_tf1_set pulse; TL0 is not written.
- Mode 1 TL0=FF, TH0=FF with i_cpu_wr_th0=1 in the strobe cycle -> o_th0_wr=0 and no TF0 pulse; o_tl0_wr=1 with 00. Reset during the strobe cycle -> all outputs 0 next cycle.
